cpu_bus_arbiter: RTL and testbench
==================================

// Module: cpu_bus_arbiter
// PURPOSE
//  Shares the single cpu_bus_ctrl port among NREQ requesters (req 0 = instruction fetch,
//  req 1 = load/store, higher = debug/DMA). Round-robin grant, one transaction in flight,
//  latched request payload, per-transaction watchdog. Sits between the core FSM and cpu_bus_ctrl.
// PARAMETERS
//  NREQ        3    number of requesters (2..8)
//  AW          26   bus address width
//  DW          32   bus data width
//  TIMEOUT     255  max cycles waiting for bus_done before abort; 0 disables watchdog
//  FIX_PRIO    0    1: fixed priority (lowest index wins); 0: round-robin
// PORTS
//  clk          in   1          core clock
//  clr_n        in   1          asynchronous active-low reset
//  req_valid    in   NREQ       requester i wants a transaction
//  req_ready    out  NREQ       one-hot; request i accepted this cycle
//  req_addr     in   NREQ*AW    packed; slice i = address of requester i
//  req_wlen     in   NREQ*2     packed `BUS_READ_32/`BUS_WRITE_8/16/32 codes
//  req_wdata    in   NREQ*DW    packed write data
//  rsp_valid    out  NREQ       one-hot 1-cycle pulse; transaction of requester i complete
//  rsp_err      out  1          valid with rsp_valid; 1 = watchdog abort
//  rsp_rdata    out  DW         read data, valid with rsp_valid
//  bus_address  out  AW         to cpu_bus_ctrl
//  bus_wlen     out  2          to cpu_bus_ctrl
//  bus_wdata    out  DW         to cpu_bus_ctrl
//  bus_run      out  1          held high while transaction in progress
//  bus_done     in   1          1-cycle pulse from bus side: transaction finished
//  bus_rdata    in   DW         sampled when bus_done=1
//  busy         out  1          state != IDLE
// BEHAVIOUR
//  Reset (clr_n=0, async): state=IDLE; req_ready, rsp_valid, rsp_err, bus_run, busy = 0;
//   bus_address, bus_wlen, bus_wdata, rsp_rdata = 0; rr pointer = 0; watchdog = 0.
//  FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//   IDLE: if any req_valid, pick winner w; req_ready[w]=1 for exactly this cycle (registered,
//     asserted in the cycle the state moves to ISSUE); latch addr/wlen/wdata of w, owner=w.
//   ISSUE: drive latched payload on bus_*, bus_run<=1, watchdog<=0; -> WAIT.
//   WAIT: bus_run held. bus_done=1 -> capture bus_rdata into rsp_rdata, bus_run<=0, -> RESP.
//     Else watchdog++; when watchdog==TIMEOUT (TIMEOUT!=0) -> bus_run<=0, rsp_err<=1,
//     rsp_rdata<=0, -> RESP.
//   RESP: rsp_valid[owner]=1 one cycle (rsp_err valid alongside); -> IDLE; rsp_err cleared.
//  Minimum latency req accept -> rsp_valid: 3 cycles + bus latency; back-to-back throughput:
//   one transaction per (4 + bus latency) cycles; new grant only from IDLE.
//  Arbitration: round-robin searches from rr pointer upward with wrap (NREQ-1 -> 0); after a
//   grant to w, pointer = (w+1) mod NREQ. FIX_PRIO=1: lowest asserted index, pointer unused.
//  Payload latched at grant; requester may change/drop req inputs after req_ready pulse.
//   req_valid deasserting before grant = request withdrawn, no side effect.
//  Write response: rsp_rdata = sampled bus_rdata (don't-care to requester), rsp_err=0.
//  bus_done outside WAIT is ignored. bus_done on the same cycle watchdog hits TIMEOUT: done
//   wins, rsp_err=0.
//  req_valid with illegal wlen is forwarded unchanged; arbiter does not decode wlen.
//  Async reset mid-transaction: bus_run drops immediately, no rsp_valid issued; lost
//   transaction is requester's responsibility.
//  Watchdog width: $clog2(TIMEOUT+1), saturates; never wraps.
// STRUCTURE
//  Shared constants (BUS_* wlen codes) stay in bus_define.v; add `BUS_ARB_ST_* state
//  encodings (2 bits) there. One sub-module: cpu_rr_arbiter (comb. NREQ-way round-robin
//  pick from req vector + pointer, outputs one-hot grant and index); FSM, payload regs,
//  watchdog in this module.
// TESTING
//  1 Reset: hold clr_n=0 with req_valid=3'b111 -> all outputs 0, no req_ready; release ->
//    grant to req 0 next cycle.
//  2 Single read: req1 addr=26'h100, READ_32, bus_done after 5 cycles with rdata=32'hDEADBEEF
//    -> bus_run high 6 cycles, rsp_valid=3'b010, rsp_rdata=32'hDEADBEEF, rsp_err=0.
//  3 Round-robin: req_valid=3'b111 held, bus_done 1 cycle after bus_run -> grant order
//    0,1,2,0,1; with FIX_PRIO=1 -> 0,0,0.
//  4 Watchdog: TIMEOUT=8, bus_done never -> bus_run drops after 8 WAIT cycles, rsp_err=1,
//    rsp_rdata=0; bus_done pulsed later while IDLE -> ignored, no rsp_valid.
//  5 Payload latch: req2 write addr=26'h3FC, WRITE_16, wdata=32'h0000ABCD, inputs changed
//    the cycle after req_ready -> bus_address/bus_wdata keep original values until done.
//  6 Async reset asserted mid-WAIT -> bus_run and busy 0 immediately, no rsp_valid pulse.

Source files
------------

// File: rtl/cpu_bus_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// cpu_bus_arbiter_pkg
//   Shared constants for the CPU bus arbiter slice:
//   - BUS_* transfer-length codes carried on bus_wlen. The arbiter forwards
//     these codes without decoding them.
//   - Two-bit arbiter FSM state encoding.
//   - Helper that sizes the watchdog counter.
// ---------------------------------------------------------------------------
package cpu_bus_arbiter_pkg;

  localparam logic [1:0] BUS_READ_32  = 2'b00;
  localparam logic [1:0] BUS_WRITE_8  = 2'b01;
  localparam logic [1:0] BUS_WRITE_16 = 2'b10;
  localparam logic [1:0] BUS_WRITE_32 = 2'b11;

  typedef enum logic [1:0] {
    BUS_ARB_ST_IDLE  = 2'b00,
    BUS_ARB_ST_ISSUE = 2'b01,
    BUS_ARB_ST_WAIT  = 2'b10,
    BUS_ARB_ST_RESP  = 2'b11
  } bus_arb_st_e;

  // The counter must hold 0..timeout. A zero timeout disables the watchdog,
  // but the counter still needs at least one bit to remain a legal vector.
  function automatic int wd_width(input int timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction

endpackage

// File: rtl/cpu_bus_arbiter_rr.sv
// ---------------------------------------------------------------------------
// cpu_rr_arbiter
//   Combinational NREQ-way pick.
//   - Round-robin mode: the search starts at ptr_i, moves upward and wraps
//     from NREQ-1 to 0.
//   - FIX_PRIO != 0: the search always starts at 0, so the lowest index wins.
// Ports:
//   req_i  [NREQ]  request vector
//   ptr_i  [IW]    round-robin start index (ignored when FIX_PRIO != 0)
//   gnt_o  [NREQ]  one-hot grant (all zero when no request is set)
//   idx_o  [IW]    index of the granted requester
//   any_o          at least one request is set
// ---------------------------------------------------------------------------
module cpu_rr_arbiter #(
  parameter int NREQ     = 3,
  parameter int FIX_PRIO = 0,
  parameter int IW       = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   idx_o,
  output logic            any_o
);

  localparam logic [IW-1:0] LAST_IDX = IW'(NREQ - 1);

  logic [IW-1:0]     start_s;
  logic [2*NREQ-1:0] req2_s;
  logic [NREQ-1:0]   rot_s;
  logic [IW-1:0]     off_s;
  logic [IW-1:0]     room_s;
  logic              found_s;

  // Rotate the requests so the search start sits at bit 0, then take the first set bit.
  always_comb begin
    start_s = (FIX_PRIO != 0) ? '0 : ptr_i;
    req2_s  = {req_i, req_i};
    rot_s   = NREQ'(req2_s >> start_s);
    off_s   = '0;
    found_s = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      off_s   = (!found_s && rot_s[k]) ? IW'(k) : off_s;
      found_s = found_s | rot_s[k];
    end
    // The rotation offset is mapped back to an absolute index without overflow.
    // room_s is the number of steps left before the search must wrap to 0.
    room_s = LAST_IDX - start_s;
    if (off_s > room_s) begin
      idx_o = off_s - room_s - IW'(1);
    end else begin
      idx_o = start_s + off_s;
    end
    any_o = found_s;
    gnt_o = found_s ? (NREQ'(1'b1) << idx_o) : '0;
  end

endmodule

// File: rtl/cpu_bus_arbiter.sv
// ---------------------------------------------------------------------------
// cpu_bus_arbiter
//   Shares the single cpu_bus_ctrl port among NREQ requesters.
//   - Requester 0 is instruction fetch, 1 is load/store, higher indices are
//     debug/DMA.
//   - Only one transaction is in flight at a time.
//   - The request payload is latched at grant.
//   - A per-transaction watchdog aborts a stuck bus.
//   FSM sequence: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//   Every output is driven from a register.
// Ports:
//   clk, clr_n               core clock, async active-low reset
//   req_valid / req_ready    per-requester request / one-cycle accept pulse
//   req_addr/wlen/wdata      packed per-requester payload
//   rsp_valid/rsp_err/rdata  one-hot completion pulse, abort flag, read data
//   bus_address/wlen/wdata   payload to cpu_bus_ctrl
//   bus_run                  high while the transaction is in progress
//   bus_done / bus_rdata     completion pulse and read data from the bus side
//   busy                     FSM not idle
// ---------------------------------------------------------------------------
module cpu_bus_arbiter
  import cpu_bus_arbiter_pkg::*;
#(
  parameter int NREQ     = 3,
  parameter int AW       = 26,
  parameter int DW       = 32,
  parameter int TIMEOUT  = 255,
  parameter int FIX_PRIO = 0
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*2-1:0] req_wlen,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]   rsp_valid,
  output logic              rsp_err,
  output logic [DW-1:0]     rsp_rdata,
  output logic [AW-1:0]     bus_address,
  output logic [1:0]        bus_wlen,
  output logic [DW-1:0]     bus_wdata,
  output logic              bus_run,
  input  logic              bus_done,
  input  logic [DW-1:0]     bus_rdata,
  output logic              busy
);

  localparam int              IW       = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int              WD_W     = wd_width(TIMEOUT);
  localparam bit              WD_EN    = (TIMEOUT != 0);
  localparam logic [WD_W-1:0] WD_LAST  = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [WD_W-1:0] WD_MAX   = WD_W'((TIMEOUT > 0) ? TIMEOUT : 0);
  localparam logic [IW-1:0]   LAST_IDX = IW'(NREQ - 1);

  bus_arb_st_e     st_q, st_d;
  logic [NREQ-1:0] req_ready_q, req_ready_d;
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic            rsp_err_q, rsp_err_d;
  logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [AW-1:0]   bus_address_q, bus_address_d;
  logic [1:0]      bus_wlen_q, bus_wlen_d;
  logic [DW-1:0]   bus_wdata_q, bus_wdata_d;
  logic            bus_run_q, bus_run_d;
  logic            busy_q, busy_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [WD_W-1:0] wd_q, wd_d;

  logic [NREQ-1:0] rr_gnt_s;
  logic [IW-1:0]   rr_idx_s;
  logic            rr_any_s;
  logic [AW-1:0]   addr_sel_s;
  logic [1:0]      wlen_sel_s;
  logic [DW-1:0]   wdata_sel_s;
  logic            wd_expire_s;

  cpu_rr_arbiter #(
    .NREQ     (NREQ),
    .FIX_PRIO (FIX_PRIO),
    .IW       (IW)
  ) u_rr (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (rr_gnt_s),
    .idx_o (rr_idx_s),
    .any_o (rr_any_s)
  );

  // The winner's payload slice is selected by its one-hot grant.
  always_comb begin
    addr_sel_s  = '0;
    wlen_sel_s  = '0;
    wdata_sel_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      addr_sel_s  = rr_gnt_s[i] ? req_addr[i*AW +: AW]   : addr_sel_s;
      wlen_sel_s  = rr_gnt_s[i] ? req_wlen[i*2 +: 2]     : wlen_sel_s;
      wdata_sel_s = rr_gnt_s[i] ? req_wdata[i*DW +: DW]  : wdata_sel_s;
    end
  end

  // Watchdog fires on the WAIT cycle in which the incremented count reaches TIMEOUT.
  assign wd_expire_s = WD_EN && (wd_q == WD_LAST);

  // FSM state register.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      st_q <= BUS_ARB_ST_IDLE;
    end else begin
      st_q <= st_d;
    end
  end

  // FSM next-state logic. bus_done takes priority over a watchdog expiry in the same cycle.
  always_comb begin
    st_d = st_q;
    case (st_q)
      BUS_ARB_ST_IDLE:  st_d = rr_any_s ? BUS_ARB_ST_ISSUE : BUS_ARB_ST_IDLE;
      BUS_ARB_ST_ISSUE: st_d = BUS_ARB_ST_WAIT;
      BUS_ARB_ST_WAIT:  st_d = (bus_done || wd_expire_s) ? BUS_ARB_ST_RESP : BUS_ARB_ST_WAIT;
      BUS_ARB_ST_RESP:  st_d = BUS_ARB_ST_IDLE;
      default:          st_d = BUS_ARB_ST_IDLE;
    endcase
  end

  // FSM output logic: next values of the registered outputs and the bookkeeping registers.
  always_comb begin
    req_ready_d   = '0;
    rsp_valid_d   = '0;
    rsp_err_d     = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    bus_address_d = bus_address_q;
    bus_wlen_d    = bus_wlen_q;
    bus_wdata_d   = bus_wdata_q;
    bus_run_d     = bus_run_q;
    owner_d       = owner_q;
    rr_ptr_d      = rr_ptr_q;
    wd_d          = wd_q;
    busy_d        = (st_d != BUS_ARB_ST_IDLE);
    case (st_q)
      BUS_ARB_ST_IDLE: begin
        if (rr_any_s) begin
          // The payload is latched straight into the bus registers. The requester
          // is then free to change its inputs after the req_ready pulse.
          req_ready_d   = rr_gnt_s;
          bus_address_d = addr_sel_s;
          bus_wlen_d    = wlen_sel_s;
          bus_wdata_d   = wdata_sel_s;
          owner_d       = rr_idx_s;
          if (FIX_PRIO == 0) begin
            rr_ptr_d = (rr_idx_s == LAST_IDX) ? '0 : rr_idx_s + IW'(1);
          end else begin
            rr_ptr_d = rr_ptr_q;
          end
        end else begin
          req_ready_d = '0;
        end
      end
      BUS_ARB_ST_ISSUE: begin
        bus_run_d = 1'b1;
        wd_d      = '0;
      end
      BUS_ARB_ST_WAIT: begin
        if (bus_done) begin
          bus_run_d   = 1'b0;
          rsp_rdata_d = bus_rdata;
          rsp_valid_d = NREQ'(1'b1) << owner_q;
        end else if (wd_expire_s) begin
          bus_run_d   = 1'b0;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          rsp_valid_d = NREQ'(1'b1) << owner_q;
        end else begin
          wd_d = (wd_q == WD_MAX) ? wd_q : wd_q + WD_W'(1);
        end
      end
      BUS_ARB_ST_RESP: begin
        rsp_valid_d = '0;
      end
      default: begin
        bus_run_d = 1'b0;
      end
    endcase
  end

  // Registers for the outputs and the bookkeeping state.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      req_ready_q   <= '0;
      rsp_valid_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_rdata_q   <= '0;
      bus_address_q <= '0;
      bus_wlen_q    <= 2'b00;
      bus_wdata_q   <= '0;
      bus_run_q     <= 1'b0;
      busy_q        <= 1'b0;
      owner_q       <= '0;
      rr_ptr_q      <= '0;
      wd_q          <= '0;
    end else begin
      req_ready_q   <= req_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_err_q     <= rsp_err_d;
      rsp_rdata_q   <= rsp_rdata_d;
      bus_address_q <= bus_address_d;
      bus_wlen_q    <= bus_wlen_d;
      bus_wdata_q   <= bus_wdata_d;
      bus_run_q     <= bus_run_d;
      busy_q        <= busy_d;
      owner_q       <= owner_d;
      rr_ptr_q      <= rr_ptr_d;
      wd_q          <= wd_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign bus_address = bus_address_q;
  assign bus_wlen    = bus_wlen_q;
  assign bus_wdata   = bus_wdata_q;
  assign bus_run     = bus_run_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Scoreboard bench for cpu_bus_arbiter.
// The main instance runs round-robin with TIMEOUT=8. A second instance with
// FIX_PRIO=1 shares the payload inputs and checks fixed-priority grant order.
module tb_cpu_bus_arbiter;
  import cpu_bus_arbiter_pkg::*;

  localparam int NREQ = 3;
  localparam int AW   = 26;
  localparam int DW   = 32;

  typedef struct {
    int         idx;
    logic       err;
    logic [31:0] rdata;
  } rsp_t;

  logic              clk = 1'b0;
  logic              clr_n = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_valid_fp = '0;
  logic [NREQ*AW-1:0] req_addr = '0;
  logic [NREQ*2-1:0] req_wlen = '0;
  logic [NREQ*DW-1:0] req_wdata = '0;
  logic              bus_done = 1'b0;
  logic              bus_done_fp = 1'b0;
  logic [DW-1:0]     bus_rdata = '0;

  logic [NREQ-1:0]   req_ready, rsp_valid, req_ready_fp, rsp_valid_fp;
  logic              rsp_err, rsp_err_fp, bus_run, bus_run_fp, busy, busy_fp;
  logic [DW-1:0]     rsp_rdata, rsp_rdata_fp, bus_wdata, bus_wdata_fp;
  logic [AW-1:0]     bus_address, bus_address_fp;
  logic [1:0]        bus_wlen, bus_wlen_fp;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   exp_gnt[$];
  int   exp_gnt_fp[$];
  rsp_t exp_rsp[$];

  int   bus_dly = 0;
  int   run_cnt = 0;
  int   last_run_len = 0;
  int   run_cnt_fp = 0;
  logic manual_done = 1'b0;

  cpu_bus_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(8), .FIX_PRIO(0)) dut (
    .clk(clk), .clr_n(clr_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_wlen(req_wlen), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .bus_address(bus_address), .bus_wlen(bus_wlen), .bus_wdata(bus_wdata),
    .bus_run(bus_run), .bus_done(bus_done), .bus_rdata(bus_rdata), .busy(busy)
  );

  cpu_bus_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(8), .FIX_PRIO(1)) dut_fp (
    .clk(clk), .clr_n(clr_n), .req_valid(req_valid_fp), .req_ready(req_ready_fp),
    .req_addr(req_addr), .req_wlen(req_wlen), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_fp), .rsp_err(rsp_err_fp), .rsp_rdata(rsp_rdata_fp),
    .bus_address(bus_address_fp), .bus_wlen(bus_wlen_fp), .bus_wdata(bus_wdata_fp),
    .bus_run(bus_run_fp), .bus_done(bus_done_fp), .bus_rdata(bus_rdata), .busy(busy_fp)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Bus model for the main DUT.
  // bus_dly = -1 means bus_done is never returned.
  // Otherwise bus_done is raised in WAIT cycle (bus_dly+1).
  initial begin
    forever begin
      @(negedge clk);
      if (bus_run) begin
        run_cnt++;
        bus_done = (bus_dly >= 0) && (run_cnt == bus_dly + 1);
      end else begin
        if (run_cnt != 0) last_run_len = run_cnt;
        run_cnt  = 0;
        bus_done = manual_done;
      end
    end
  end

  // Bus model for the fixed-priority DUT: bus_done is returned in the second WAIT cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (bus_run_fp) begin
        run_cnt_fp++;
        bus_done_fp = (run_cnt_fp == 2);
      end else begin
        run_cnt_fp  = 0;
        bus_done_fp = 1'b0;
      end
    end
  end

  // Monitor: pops expectations whenever a DUT presents a grant or a response.
  initial begin
    int   e;
    rsp_t r;
    logic [NREQ-1:0] oh;
    forever begin
      @(negedge clk);
      if (req_ready != '0) begin
        if (exp_gnt.size() == 0) begin
          check("unexpected_grant", 64'(req_ready), 64'(0));
        end else begin
          e  = exp_gnt.pop_front();
          oh = 3'b001 << e;
          check("grant", 64'(req_ready), 64'(oh));
        end
      end
      if (req_ready_fp != '0) begin
        if (exp_gnt_fp.size() == 0) begin
          check("unexpected_grant_fp", 64'(req_ready_fp), 64'(0));
        end else begin
          e  = exp_gnt_fp.pop_front();
          oh = 3'b001 << e;
          check("grant_fp", 64'(req_ready_fp), 64'(oh));
        end
      end
      if (rsp_valid != '0) begin
        if (exp_rsp.size() == 0) begin
          check("unexpected_rsp", 64'(rsp_valid), 64'(0));
        end else begin
          r  = exp_rsp.pop_front();
          oh = 3'b001 << r.idx;
          check("rsp_valid", 64'(rsp_valid), 64'(oh));
          check("rsp_err", 64'(rsp_err), 64'(r.err));
          check("rsp_rdata", 64'(rsp_rdata), 64'(r.rdata));
        end
      end
    end
  end

  task automatic wait_grant(input int idx);
    bit got;
    got = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (req_ready[idx]) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check("grant_timeout", 64'(0), 64'(1));
  endtask

  task automatic wait_rsp();
    bit got;
    got = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (exp_rsp.size() == 0) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check("rsp_timeout", 64'(exp_rsp.size()), 64'(0));
    @(negedge clk);
  endtask

  task automatic push_rsp(input int idx, input logic err, input logic [31:0] rd);
    rsp_t r;
    r.idx = idx;
    r.err = err;
    r.rdata = rd;
    exp_rsp.push_back(r);
  endtask

  initial begin
    int ng;
    int bad_hold;
    int hold_samples;

    // 1: Reset held with every request asserted. All outputs stay 0, then req 0 is granted.
    req_valid = 3'b111;
    bus_dly = 0;
    bus_rdata = 32'h0BAD_F00D;
    repeat (3) @(negedge clk);
    check("rst_ctrl", 64'({req_ready, rsp_valid, rsp_err, bus_run, busy, bus_wlen}), 64'(0));
    check("rst_rdata", 64'(rsp_rdata), 64'(0));
    check("rst_addr", 64'(bus_address), 64'(0));
    check("rst_wdata", 64'(bus_wdata), 64'(0));
    exp_gnt.push_back(0);
    push_rsp(0, 1'b0, 32'h0BAD_F00D);
    clr_n = 1'b1;
    wait_grant(0);
    req_valid = '0;
    wait_rsp();

    // 2: Single read from requester 1. bus_done arrives after 5 WAIT cycles.
    bus_dly = 5;
    bus_rdata = 32'hDEAD_BEEF;
    req_addr[1*AW +: AW] = 26'h100;
    req_wlen[1*2 +: 2] = BUS_READ_32;
    exp_gnt.push_back(1);
    push_rsp(1, 1'b0, 32'hDEAD_BEEF);
    req_valid = 3'b010;
    wait_grant(1);
    req_valid = '0;
    @(negedge clk);
    check("read_addr", 64'(bus_address), 64'(26'h100));
    wait_rsp();
    check("read_run_len", 64'(last_run_len), 64'(6));

    // 3: Reset, then hold all requests. Expected order is RR 0,1,2,0,1 and fixed-priority 0 x5.
    @(negedge clk);
    clr_n = 1'b0;
    repeat (2) @(negedge clk);
    clr_n = 1'b1;
    bus_dly = 1;
    bus_rdata = 32'h1234_5678;
    begin
      int order[5] = '{0, 1, 2, 0, 1};
      foreach (order[k]) begin
        exp_gnt.push_back(order[k]);
        push_rsp(order[k], 1'b0, 32'h1234_5678);
        exp_gnt_fp.push_back(0);
      end
    end
    req_valid = 3'b111;
    req_valid_fp = 3'b111;
    ng = 0;
    for (int n = 0; n < 200 && ng < 5; n++) begin
      @(negedge clk);
      if (req_ready != '0) ng++;
    end
    req_valid = '0;
    req_valid_fp = '0;
    check("rr_grant_count", 64'(ng), 64'(5));
    wait_rsp();
    repeat (4) @(negedge clk);
    check("fp_pending", 64'(exp_gnt_fp.size()), 64'(0));
    check("rr_run_len", 64'(last_run_len), 64'(2));

    // 4: Watchdog abort after 8 WAIT cycles. A later bus_done while IDLE is ignored.
    bus_dly = -1;
    bus_rdata = 32'hCAFE_F00D;
    req_addr[0*AW +: AW] = 26'h40;
    req_wlen[0*2 +: 2] = BUS_READ_32;
    exp_gnt.push_back(0);
    push_rsp(0, 1'b1, 32'h0);
    req_valid = 3'b001;
    wait_grant(0);
    req_valid = '0;
    wait_rsp();
    check("wd_run_len", 64'(last_run_len), 64'(8));
    manual_done = 1'b1;
    @(negedge clk);
    @(negedge clk);
    manual_done = 1'b0;
    repeat (6) @(negedge clk);
    check("wd_idle_busy", 64'({busy, bus_run}), 64'(0));

    // 5: Write from requester 2. The requester inputs change right after req_ready,
    //    and the bus payload must stay at the latched values.
    bus_dly = 4;
    bus_rdata = 32'h5555_AAAA;
    req_addr[2*AW +: AW] = 26'h3FC;
    req_wlen[2*2 +: 2] = BUS_WRITE_16;
    req_wdata[2*DW +: DW] = 32'h0000_ABCD;
    exp_gnt.push_back(2);
    push_rsp(2, 1'b0, 32'h5555_AAAA);
    req_valid = 3'b100;
    wait_grant(2);
    req_valid = '0;
    req_addr[2*AW +: AW] = 26'h3FF_FFFF;
    req_wlen[2*2 +: 2] = BUS_WRITE_32;
    req_wdata[2*DW +: DW] = 32'hFFFF_FFFF;
    bad_hold = 0;
    hold_samples = 0;
    for (int n = 0; n < 50 && exp_rsp.size() != 0; n++) begin
      @(negedge clk);
      if (bus_run) begin
        hold_samples++;
        if (bus_address !== 26'h3FC || bus_wdata !== 32'h0000_ABCD || bus_wlen !== BUS_WRITE_16)
          bad_hold++;
      end
    end
    check("payload_hold_bad", 64'(bad_hold), 64'(0));
    check("payload_hold_samples", 64'(hold_samples), 64'(5));
    wait_rsp();

    // 6: Async reset asserted mid-WAIT. bus_run and busy must drop at once,
    //    and no response may be issued.
    bus_dly = -1;
    req_addr[1*AW +: AW] = 26'h200;
    exp_gnt.push_back(1);
    req_valid = 3'b010;
    wait_grant(1);
    req_valid = '0;
    repeat (3) @(negedge clk);
    check("mid_wait_run", 64'({bus_run, busy}), 64'(2'b11));
    #2;
    clr_n = 1'b0;
    #1;
    check("async_rst_run_busy", 64'({bus_run, busy}), 64'(0));
    repeat (3) @(negedge clk);
    clr_n = 1'b1;
    repeat (12) @(negedge clk);
    check("final_gnt_q", 64'(exp_gnt.size()), 64'(0));
    check("final_rsp_q", 64'(exp_rsp.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
